// File: rtl/rv32_pkg.sv
// rv32_pkg: constants shared by the rv32 core and its memory-port arbiter.
// Holds the memory-port width defaults, the arbiter's one-hot state indices and the requester IDs.
package rv32_pkg;
   localparam int MEM_ADDR_WIDTH = 32;
   localparam int MEM_DATA_WIDTH = 32;
   localparam int MEM_READ_LATENCY = 2;
   localparam int IDLE = 0;
   localparam int ISSUE = 1;
   localparam int WAIT = 2;
   typedef logic [2:0] arb_state_t;
   localparam arb_state_t ST_IDLE = 3'b001;
   localparam arb_state_t ST_ISSUE = 3'b010;
   localparam arb_state_t ST_WAIT = 3'b100;
   localparam logic REQ_FETCH = 1'b0;
   localparam logic REQ_DATA = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data request handshakes and the shared memory port.
// The master modport is the core-plus-memory side; the slave modport is the arbiter.
interface mem_port_arbiter_if import rv32_pkg::*; #(
   parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
   parameter int DATA_WIDTH = MEM_DATA_WIDTH
);
   logic i_req;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic i_gnt;
   logic i_rvalid;
   logic [DATA_WIDTH-1:0] i_rdata;
   logic d_req;
   logic d_we;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [DATA_WIDTH-1:0] d_wdata;
   logic d_gnt;
   logic d_rvalid;
   logic [DATA_WIDTH-1:0] d_rdata;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic mem_rd;
   logic mem_wr;
   logic [DATA_WIDTH-1:0] mem_rdata;
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, mem_addr, mem_wdata, mem_rd, mem_wr
   );
   modport slave (
      input i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, mem_addr, mem_wdata, mem_rd, mem_wr
   );
endinterface

// File: rtl/arb_rr2.sv
// arb_rr2: combinational two-way round-robin picker; on a tie the requester not granted last wins.
module arb_rr2 import rv32_pkg::*; (
   input logic [1:0] reqs,
   input logic last,
   output logic [1:0] pick
);
   always_comb pick = (reqs == 2'b11) ? ((last == REQ_DATA) ? 2'b01 : 2'b10) : reqs;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (read-only) and data (read/write),
// one request at a time, round-robin, routing read completions back after READ_LATENCY cycles.
module mem_port_arbiter import rv32_pkg::*; #(
   parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
   parameter int DATA_WIDTH = MEM_DATA_WIDTH,
   parameter int READ_LATENCY = MEM_READ_LATENCY
) (
   input logic clk,
   input logic reset,
   mem_port_arbiter_if.slave bus
);
   localparam int CW = $clog2(READ_LATENCY + 1);
   arb_state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic owner, we, last;
   logic [1:0] pick;
   logic win_we, rd_q, wr_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   arb_rr2 u_arb (.reqs({bus.d_req, bus.i_req}), .last(last), .pick(pick));
   assign win_we = pick[1] & bus.d_we;

   always_ff @(posedge clk) state <= reset ? ST_IDLE : state_nx;

   always_comb begin
      state_nx = state;
      if (state[IDLE]) state_nx = (|pick) ? ST_ISSUE : ST_IDLE;
      if (state[ISSUE]) state_nx = we ? ST_IDLE : ST_WAIT;
      if (state[WAIT]) state_nx = (cnt == CW'(1)) ? ST_IDLE : ST_WAIT;
   end

   // Strobes are registered so mem_rd/mem_wr come straight from flops during ISSUE.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner <= REQ_FETCH;
         we <= 1'b0;
         rd_q <= 1'b0;
         wr_q <= 1'b0;
         last <= REQ_FETCH;
         cnt <= '0;
         addr_q <= '0;
         wdata_q <= '0;
      end else begin
         rd_q <= state[IDLE] & (|pick) & ~win_we;
         wr_q <= state[IDLE] & win_we;
         if (state[IDLE] && (|pick)) begin
            owner <= pick[1];
            we <= win_we;
            addr_q <= pick[1] ? bus.d_addr : bus.i_addr;
            if (win_we) wdata_q <= bus.d_wdata;
         end
         if (state[ISSUE]) begin
            last <= owner;
            cnt <= CW'(READ_LATENCY);
         end
         if (state[WAIT]) cnt <= cnt - CW'(1);
      end
   end

   always_comb begin
      bus.i_gnt = state[ISSUE] & (owner == REQ_FETCH);
      bus.d_gnt = state[ISSUE] & (owner == REQ_DATA);
      bus.i_rvalid = state[WAIT] & (cnt == CW'(1)) & (owner == REQ_FETCH);
      bus.d_rvalid = state[WAIT] & (cnt == CW'(1)) & (owner == REQ_DATA);
   end

   assign bus.mem_rd = rd_q;
   assign bus.mem_wr = wr_q;
   assign bus.mem_addr = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.i_rdata = bus.mem_rdata;
   assign bus.d_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand-written multi-cycle sequences
// for the main READ_LATENCY=2 build and back-to-back reads on READ_LATENCY=1 and 4 builds.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if bus ();
   mem_port_arbiter_if b1 ();
   mem_port_arbiter_if b4 ();

   mem_port_arbiter #(.READ_LATENCY(2)) dut (.clk(clk), .reset(reset), .bus(bus));
   mem_port_arbiter #(.READ_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
   mem_port_arbiter #(.READ_LATENCY(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));

   typedef struct {
      logic rst;
      logic ir;
      logic [31:0] ia;
      logic dr;
      logic dw;
      logic [31:0] da;
      logic [31:0] dwd;
      logic [5:0] fl;
      logic [31:0] ma;
      logic [31:0] mwd;
   } vec_t;

   vec_t v [19];
   logic exp_owner;
   int w;
   int rd1[$], rv1[$], rd4[$], rv4[$];
   logic bad1, bad4;

   task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h expected=%h", nm, got, exp);
      end
   endtask

   task automatic rl_check(input string nm, input int rl, input int rd[$], input int rv[$], input logic bad);
      chk({nm, "_count"}, 160'(rd.size() >= 4 && rv.size() >= 3), 160'(1));
      chk({nm, "_other"}, 160'(bad), 160'(0));
      if (rd.size() >= 4 && rv.size() >= 3) begin
         chk({nm, "_first"}, 160'(rd[0]), 160'(1));
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_lat%0d", nm, k), 160'(rv[k] - rd[k]), 160'(rl));
            chk($sformatf("%s_per%0d", nm, k), 160'(rd[k+1] - rd[k]), 160'(rl + 2));
         end
      end
   endtask

   task automatic wait_gnt();
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!(bus.i_gnt | bus.d_gnt) && w < 8);
   endtask

   initial begin
      {bus.i_req, bus.d_req, bus.d_we} = 3'b000;
      bus.i_addr = '0;
      bus.d_addr = '0;
      bus.d_wdata = '0;
      bus.mem_rdata = 32'hDEADBEEF;
      {b1.i_req, b1.d_req, b1.d_we} = 3'b010;
      {b4.i_req, b4.d_req, b4.d_we} = 3'b010;
      b1.i_addr = '0;
      b4.i_addr = '0;
      b1.d_addr = 32'h80;
      b4.d_addr = 32'h80;
      b1.d_wdata = '0;
      b4.d_wdata = '0;
      b1.mem_rdata = 32'h11111111;
      b4.mem_rdata = 32'h44444444;
      //                 rst  ir   ia      dr   dw   da      dwd            {gi,vi,gd,vd,rd,wr} ma  mwd
      v[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,        6'b000000, 32'h00, 32'h0};
      v[1]  = '{1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h00, 32'h0,        6'b000000, 32'h00, 32'h0};
      v[2]  = '{1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h00, 32'h0,        6'b000000, 32'h00, 32'h0};
      v[3]  = '{1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h00, 32'h0,        6'b100010, 32'h10, 32'h0};
      v[4]  = '{1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h00, 32'h0,        6'b000000, 32'h10, 32'h0};
      v[5]  = '{1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h00, 32'h0,        6'b010000, 32'h10, 32'h0};
      v[6]  = '{1'b0, 1'b0, 32'h10, 1'b1, 1'b1, 32'h40, 32'h12345678, 6'b000000, 32'h10, 32'h0};
      v[7]  = '{1'b0, 1'b0, 32'h10, 1'b1, 1'b1, 32'h40, 32'h12345678, 6'b001001, 32'h40, 32'h12345678};
      v[8]  = '{1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 32'h44, 32'h12345678, 6'b000000, 32'h40, 32'h12345678};
      v[9]  = '{1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 32'h44, 32'h12345678, 6'b001010, 32'h44, 32'h12345678};
      v[10] = '{1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h44, 32'h12345678, 6'b000000, 32'h44, 32'h12345678};
      v[11] = '{1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h44, 32'h12345678, 6'b000100, 32'h44, 32'h12345678};
      v[12] = '{1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 32'h48, 32'hCAFEF00D, 6'b000000, 32'h44, 32'h12345678};
      v[13] = '{1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 32'h48, 32'hCAFEF00D, 6'b100010, 32'h20, 32'h12345678};
      v[14] = '{1'b0, 1'b0, 32'h20, 1'b1, 1'b1, 32'h48, 32'hCAFEF00D, 6'b000000, 32'h20, 32'h12345678};
      v[15] = '{1'b0, 1'b0, 32'h20, 1'b1, 1'b1, 32'h48, 32'hCAFEF00D, 6'b010000, 32'h20, 32'h12345678};
      v[16] = '{1'b0, 1'b0, 32'h20, 1'b1, 1'b1, 32'h48, 32'hCAFEF00D, 6'b000000, 32'h20, 32'h12345678};
      v[17] = '{1'b0, 1'b0, 32'h20, 1'b1, 1'b1, 32'h48, 32'hCAFEF00D, 6'b001001, 32'h48, 32'hCAFEF00D};
      v[18] = '{1'b0, 1'b0, 32'h20, 1'b0, 1'b0, 32'h48, 32'hCAFEF00D, 6'b000000, 32'h48, 32'hCAFEF00D};
      foreach (v[k]) begin
         @(posedge clk);
         #1;
         reset = v[k].rst;
         bus.i_req = v[k].ir;
         bus.i_addr = v[k].ia;
         bus.d_req = v[k].dr;
         bus.d_we = v[k].dw;
         bus.d_addr = v[k].da;
         bus.d_wdata = v[k].dwd;
         @(negedge clk);
         chk($sformatf("vec%0d", k),
             160'({bus.i_gnt, bus.i_rvalid, bus.d_gnt, bus.d_rvalid, bus.mem_rd, bus.mem_wr,
                   bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata}),
             160'({v[k].fl, v[k].ma, v[k].mwd, 32'hDEADBEEF, 32'hDEADBEEF}));
      end
      // Both requesting reads continuously after reset: data wins first, then strict alternation.
      @(posedge clk);
      #1;
      reset = 1'b1;
      {bus.i_req, bus.d_req, bus.d_we} = 3'b110;
      bus.i_addr = 32'h100;
      bus.d_addr = 32'h200;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_owner = 1'b1;
      for (int g = 0; g < 8; g++) begin
         wait_gnt();
         chk($sformatf("tie_gnt%0d", g),
             160'({bus.i_gnt, bus.d_gnt, bus.mem_rd, bus.mem_wr, bus.mem_addr, w}),
             160'({~exp_owner, exp_owner, 1'b1, 1'b0, exp_owner ? 32'h200 : 32'h100, 32'd2}));
         w = 0;
         do begin
            @(negedge clk);
            w++;
         end while (!(bus.i_rvalid | bus.d_rvalid) && w < 8);
         chk($sformatf("tie_rvalid%0d", g), 160'({bus.i_rvalid, bus.d_rvalid, w}),
             160'({~exp_owner, exp_owner, 32'd2}));
         exp_owner = ~exp_owner;
      end
      // Reset during the first WAIT cycle of a fetch read discards it; the held i_req is re-granted.
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus.d_req = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      wait_gnt();
      chk("rst_pre_gnt", 160'({bus.i_gnt, bus.mem_rd, bus.mem_addr, w}), 160'({2'b11, 32'h100, 32'd2}));
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("rst_wait", 160'({bus.i_rvalid, bus.d_rvalid, bus.i_gnt}), 160'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_zero",
          160'({bus.i_gnt, bus.i_rvalid, bus.d_gnt, bus.d_rvalid, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata}),
          160'(0));
      @(negedge clk);
      chk("rst_regrant", 160'({bus.i_gnt, bus.d_gnt, bus.mem_rd, bus.mem_addr}), 160'({3'b101, 32'h100}));
      // Back-to-back data reads on the READ_LATENCY=1 and 4 builds.
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus.i_req = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      bad1 = 1'b0;
      bad4 = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (b1.mem_rd) rd1.push_back(c);
         if (b1.d_rvalid) rv1.push_back(c);
         if (b4.mem_rd) rd4.push_back(c);
         if (b4.d_rvalid) rv4.push_back(c);
         bad1 = bad1 | b1.i_rvalid | b1.i_gnt | b1.mem_wr;
         bad4 = bad4 | b4.i_rvalid | b4.i_gnt | b4.mem_wr;
      end
      rl_check("rl1", 1, rd1, rv1, bad1);
      rl_check("rl4", 4, rd4, rv4, bad4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between two requesters: the instruction-fetch path (read-only) and the data load/store path (read/write). It sits between the rv32 sequencer and memory and owns mem_rd/mem_wr/mem_addr. Requests are accepted one at a time under round-robin arbitration, and each read completion is routed back to the requester that issued it. The arbiter also enforces memory read latency, so the core no longer needs delay states of its own.

## Interface
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width
- READ_LATENCY, 2, cycles from the mem_rd cycle to valid mem_rdata; legal values are ≥1

- clk  in  1  clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request; held until i_gnt
- i_addr  in  ADDR_WIDTH  fetch address; stable while i_req is high
- i_gnt  out  1  one-cycle grant strobe
- i_rvalid  out  1  one-cycle fetch data-valid strobe
- i_rdata  out  DATA_WIDTH  equals mem_rdata (combinational)
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = write, 0 = read; stable while d_req is high
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  write data
- d_gnt  out  1  one-cycle grant strobe
- d_rvalid  out  1  one-cycle load data-valid strobe
- d_rdata  out  DATA_WIDTH  equals mem_rdata (combinational)
- mem_addr  out  ADDR_WIDTH  registered memory address
- mem_wdata  out  DATA_WIDTH  registered write data
- mem_rd  out  1  registered read strobe
- mem_wr  out  1  registered write strobe
- mem_rdata  in  DATA_WIDTH  memory read data

## Operation
- States (one-hot):
  - IDLE
  - ISSUE
  - WAIT, with a down-counter of width clog2(READ_LATENCY+1)
- IDLE
  - Samples i_req and d_req.
  - If either is high: pick the winner, register winner addr/wdata/we and owner ID, go to ISSUE.
  - If neither is high: stay in IDLE.
- Arbitration: round-robin on a last-granted pointer.
  - If both request, the requester not granted last wins.
  - If only one requests, it wins.
  - Pointer resets to "fetch last", so data wins the first tie.
- ISSUE (exactly one cycle)
  - Winner's gnt is high, plus mem_rd (read) or mem_wr (write).
  - Requests are not sampled in this cycle; the requester may drop req only after seeing gnt.
  - Write: go to IDLE. No rvalid is produced.
  - Read: go to WAIT with counter = READ_LATENCY.
- WAIT
  - Counter decrements each cycle.
  - In the cycle the counter reaches 1, the owner's rvalid is high (the other requester's rvalid stays low) and the next state is IDLE.
- Fetch requests are always reads. d_we is ignored unless data wins.
- mem_addr and mem_wdata hold their last values outside ISSUE. mem_rd and mem_wr are 0 outside ISSUE.
- Any req still high after its gnt counts as a new request in the next IDLE cycle.

## Timing
- Reset values: state IDLE, all gnt/rvalid/mem_rd/mem_wr 0, mem_addr 0, mem_wdata 0, pointer "fetch last".
- Read: req sampled in IDLE at cycle T → gnt + mem_rd in T+1 → rvalid in T+1+READ_LATENCY → IDLE in T+2+READ_LATENCY.
- With the default READ_LATENCY, a back-to-back read is issued every READ_LATENCY+2 = 4 cycles.
- Write: req sampled at T → gnt + mem_wr in T+1 → IDLE at T+2, so 2 cycles per write.
- Both requests high continuously: grants alternate strictly d, i, d, i, …
- Reset asserted in any state: next cycle is IDLE with reset values. An in-flight read is discarded and no rvalid is produced. A pending req is re-arbitrated after reset deasserts.
- Reset held with req high: no gnt while reset is high.

## Structure
- Shared package (rv32_pkg) holds:
  - the arbiter state encoding (one-hot indices IDLE/ISSUE/WAIT)
  - the requester ID constants (REQ_FETCH = 0, REQ_DATA = 1)
  - the memory-port width defaults, shared with rv32
- One sub-module, arb_rr2: a combinational two-way round-robin picker.
  - Inputs: reqs[1:0], last[0].
  - Outputs: one-hot pick[1:0].
- The FSM, counter, registered outputs, and pointer update (on ISSUE only) live in mem_port_arbiter.

## Test plan
- Reset, then only i_req with i_addr=0x10 and mem_rdata=0xDEADBEEF available 2 cycles after mem_rd → i_gnt and mem_rd with mem_addr=0x10 one cycle after sampling; i_rvalid 2 cycles later with i_rdata=0xDEADBEEF; d_rvalid stays 0.
- d_req with d_we=1, d_addr=0x40, d_wdata=0x12345678 → single mem_wr cycle with those values; no rvalid; next grant possible 2 cycles after the first sample.
- i_req and d_req held high for 8 grants → order d, i, d, i, d, i, d, i; each read rvalid goes only to its owner.
- Reset pulsed during WAIT of a fetch read → no i_rvalid; all outputs 0 the next cycle; a held i_req is re-granted after reset.
- READ_LATENCY=1 and READ_LATENCY=4 builds with back-to-back data reads → rvalid exactly READ_LATENCY cycles after mem_rd; period of READ_LATENCY+2.
- Requester keeps req high for one cycle after gnt → treated as a second, distinct transaction; no duplicate grant in the ISSUE cycle.
